// File: rtl/tap_multichannel.sv
// JTAG TAP with IEEE 1149.1 controller, parametrised IR, BYPASS, IDCODE, boundary scan
// and USER_N independent user data registers with capture/update strobes toward the core.
module tap_multichannel #(
    parameter int          IR_W    = 4,
    parameter logic [31:0] IDCODE  = 32'h1000_0001,
    parameter int          BSR_IN  = 4,
    parameter int          BSR_OUT = 4,
    parameter int          USER_N  = 2,
    parameter int          USER_W  = 32
) (
    input  logic                       tck,
    input  logic                       trst,
    input  logic                       tms,
    input  logic                       tdi,
    output logic                       tdo,
    output logic                       tdo_en,
    input  logic [BSR_IN-1:0]          pins_in,
    output logic [BSR_IN-1:0]          logic_pins_in,
    input  logic [BSR_OUT-1:0]         logic_pins_out,
    output logic [BSR_OUT-1:0]         pins_out,
    input  logic [USER_N*USER_W-1:0]   user_capture_data,
    output logic [USER_N*USER_W-1:0]   user_update_data,
    output logic [USER_N-1:0]          user_capture_strobe,
    output logic [USER_N-1:0]          user_update_strobe,
    output logic [IR_W-1:0]            ir_out,
    output logic [3:0]                 tap_state
);

    localparam int BSR_W = BSR_IN + BSR_OUT;
    localparam logic [IR_W-1:0] IR_EXTEST = IR_W'(0);
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(2);

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC, SEL_DR  = 4'h7, CAP_DR  = 4'h6,
        SH_DR   = 4'h2, EX1_DR  = 4'h1, PAU_DR  = 4'h3, EX2_DR  = 4'h0,
        UPD_DR  = 4'h5, SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA,
        EX1_IR  = 4'h9, PAU_IR  = 4'hB, EX2_IR  = 4'h8, UPD_IR  = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {
        SEL_BYP  = 2'd0,
        SEL_ID   = 2'd1,
        SEL_BSR  = 2'd2,
        SEL_USER = 2'd3
    } dr_sel_e;

    tap_state_e               state_r;
    tap_state_e               next_state_s;
    dr_sel_e                  dr_sel_s;
    logic [USER_N-1:0]        user_hit_s;
    logic [USER_W-1:0]        user_cap_s;
    logic [IR_W-1:0]          ir_sh_r;
    logic [IR_W-1:0]          ir_r;
    logic                     byp_r;
    logic [31:0]              id_sh_r;
    logic [BSR_W-1:0]         bsr_sh_r;
    logic [BSR_OUT-1:0]       bsr_upd_r;
    logic [USER_W-1:0]        user_sh_r;
    logic [USER_N*USER_W-1:0] user_upd_r;
    logic [USER_N-1:0]        cap_stb_r;
    logic [USER_N-1:0]        upd_stb_r;
    logic                     tdo_en_r;
    logic                     tdo_s;

    // TAP controller next-state function on tms
    always_comb begin
        next_state_s = TLR;
        case (state_r)
            TLR:     next_state_s = tms ? TLR    : RTI;
            RTI:     next_state_s = tms ? SEL_DR : RTI;
            SEL_DR:  next_state_s = tms ? SEL_IR : CAP_DR;
            CAP_DR:  next_state_s = tms ? EX1_DR : SH_DR;
            SH_DR:   next_state_s = tms ? EX1_DR : SH_DR;
            EX1_DR:  next_state_s = tms ? UPD_DR : PAU_DR;
            PAU_DR:  next_state_s = tms ? EX2_DR : PAU_DR;
            EX2_DR:  next_state_s = tms ? UPD_DR : SH_DR;
            UPD_DR:  next_state_s = tms ? SEL_DR : RTI;
            SEL_IR:  next_state_s = tms ? TLR    : CAP_IR;
            CAP_IR:  next_state_s = tms ? EX1_IR : SH_IR;
            SH_IR:   next_state_s = tms ? EX1_IR : SH_IR;
            EX1_IR:  next_state_s = tms ? UPD_IR : PAU_IR;
            PAU_IR:  next_state_s = tms ? EX2_IR : PAU_IR;
            EX2_IR:  next_state_s = tms ? UPD_IR : SH_IR;
            UPD_IR:  next_state_s = tms ? SEL_DR : RTI;
            default: next_state_s = TLR;
        endcase
    end

    // Instruction decode; unknown codes and unused USER codes fall back to BYPASS
    always_comb begin
        dr_sel_s   = SEL_BYP;
        user_hit_s = '0;
        user_cap_s = '0;
        case (ir_r)
            IR_EXTEST, IR_SAMPLE: dr_sel_s = SEL_BSR;
            IR_IDCODE:            dr_sel_s = SEL_ID;
            default:              dr_sel_s = SEL_BYP;
        endcase
        for (int k = 0; k < USER_N; k++) begin
            if (ir_r == IR_W'(8 + k)) begin
                dr_sel_s      = SEL_USER;
                user_hit_s[k] = 1'b1;
                user_cap_s    = user_capture_data[k*USER_W +: USER_W];
            end else begin
                user_hit_s[k] = 1'b0;
            end
        end
    end

    // Controller state, shift-enable and strobe registers
    always_ff @(posedge tck) begin
        if (!trst) begin
            state_r   <= TLR;
            tdo_en_r  <= 1'b0;
            cap_stb_r <= '0;
            upd_stb_r <= '0;
        end else begin
            state_r   <= next_state_s;
            tdo_en_r  <= (next_state_s == SH_DR) || (next_state_s == SH_IR);
            // Capture strobe covers the CapDR cycle itself, update strobe the cycle after UpdDR
            cap_stb_r <= (next_state_s == CAP_DR) ? user_hit_s : '0;
            upd_stb_r <= (state_r == UPD_DR) ? user_hit_s : '0;
        end
    end

    // Instruction shift and instruction registers; entering TLR forces IDCODE
    always_ff @(posedge tck) begin
        if (!trst) begin
            ir_sh_r <= '0;
            ir_r    <= IR_IDCODE;
        end else begin
            case (state_r)
                CAP_IR:  ir_sh_r <= {{(IR_W-2){1'b0}}, 2'b01};
                SH_IR:   ir_sh_r <= {tdi, ir_sh_r[IR_W-1:1]};
                UPD_IR:  ir_r    <= ir_sh_r;
                default: ;
            endcase
            if (next_state_s == TLR) begin
                ir_r <= IR_IDCODE;
            end
        end
    end

    // Data shift registers: capture, then right shift with tdi entering the MSB
    always_ff @(posedge tck) begin
        if (!trst) begin
            byp_r     <= 1'b0;
            id_sh_r   <= '0;
            bsr_sh_r  <= '0;
            user_sh_r <= '0;
        end else if (state_r == CAP_DR) begin
            case (dr_sel_s)
                SEL_ID:   id_sh_r   <= IDCODE;
                SEL_BSR:  bsr_sh_r  <= {pins_in, logic_pins_out};
                SEL_USER: user_sh_r <= user_cap_s;
                default:  byp_r     <= 1'b0;
            endcase
        end else if (state_r == SH_DR) begin
            case (dr_sel_s)
                SEL_ID:   id_sh_r   <= {tdi, id_sh_r[31:1]};
                SEL_BSR:  bsr_sh_r  <= {tdi, bsr_sh_r[BSR_W-1:1]};
                SEL_USER: user_sh_r <= {tdi, user_sh_r[USER_W-1:1]};
                default:  byp_r     <= tdi;
            endcase
        end
    end

    // Update registers written on the UpdDR edge; retained through TLR
    always_ff @(posedge tck) begin
        if (!trst) begin
            bsr_upd_r  <= '0;
            user_upd_r <= '0;
        end else if (state_r == UPD_DR) begin
            if (dr_sel_s == SEL_BSR) begin
                bsr_upd_r <= bsr_sh_r[BSR_OUT-1:0];
            end
            for (int k = 0; k < USER_N; k++) begin
                if (user_hit_s[k]) begin
                    user_upd_r[k*USER_W +: USER_W] <= user_sh_r;
                end
            end
        end
    end

    // Serial output mux from the registered state
    always_comb begin
        tdo_s = 1'b0;
        if (state_r == SH_IR) begin
            tdo_s = ir_sh_r[0];
        end else if (state_r == SH_DR) begin
            case (dr_sel_s)
                SEL_ID:   tdo_s = id_sh_r[0];
                SEL_BSR:  tdo_s = bsr_sh_r[0];
                SEL_USER: tdo_s = user_sh_r[0];
                default:  tdo_s = byp_r;
            endcase
        end else begin
            tdo_s = 1'b0;
        end
    end

    assign tdo                 = tdo_s;
    assign tdo_en              = tdo_en_r;
    assign logic_pins_in       = pins_in;
    assign pins_out            = (ir_r == IR_EXTEST) ? bsr_upd_r : logic_pins_out;
    assign user_update_data    = user_upd_r;
    assign user_capture_strobe = cap_stb_r;
    assign user_update_strobe  = upd_stb_r;
    assign ir_out              = ir_r;
    assign tap_state           = state_r;

endmodule

// File: tb/tb_tap_multichannel.sv
// Directed self-checking bench for tap_multichannel: reset, IDCODE, BYPASS, USER
// channels, boundary scan/EXTEST, illegal codes, TLR entry and reset mid-shift.
module tb_tap_multichannel;

    logic        tck;
    logic        trst;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  pins_in;
    logic [3:0]  logic_pins_in;
    logic [3:0]  logic_pins_out;
    logic [3:0]  pins_out;
    logic [63:0] user_capture_data;
    logic [63:0] user_update_data;
    logic [1:0]  user_capture_strobe;
    logic [1:0]  user_update_strobe;
    logic [3:0]  ir_out;
    logic [3:0]  tap_state;

    int          n_cmp;
    int          n_err;
    int          cap_cnt;
    int          upd_cnt;
    logic [1:0]  cap_or;
    logic [1:0]  upd_or;
    logic [63:0] rd;
    logic [3:0]  ir_rd;

    tap_multichannel dut (
        .tck                 (tck),
        .trst                (trst),
        .tms                 (tms),
        .tdi                 (tdi),
        .tdo                 (tdo),
        .tdo_en              (tdo_en),
        .pins_in             (pins_in),
        .logic_pins_in       (logic_pins_in),
        .logic_pins_out      (logic_pins_out),
        .pins_out            (pins_out),
        .user_capture_data   (user_capture_data),
        .user_update_data    (user_update_data),
        .user_capture_strobe (user_capture_strobe),
        .user_update_strobe  (user_update_strobe),
        .ir_out              (ir_out),
        .tap_state           (tap_state)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stb();
        cap_cnt = 0;
        upd_cnt = 0;
        cap_or  = 2'b00;
        upd_or  = 2'b00;
    endtask

    // One TCK edge; called and returning at a falling edge, strobes tallied after it
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        if (user_capture_strobe != 2'b00) cap_cnt++;
        if (user_update_strobe != 2'b00) upd_cnt++;
        cap_or = cap_or | user_capture_strobe;
        upd_or = upd_or | user_update_strobe;
    endtask

    // From RTI: load IR with v, return captured bits, end in RTI
    task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
        o = 4'h0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("tdo_en_shir", tdo_en, 1'b1);
        for (int i = 0; i < 4; i++) begin
            o[i] = tdo;
            step(i == 3, v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: n-bit DR scan of v (LSB first), return shifted-out bits, end in RTI
    task automatic scan_dr(input logic [63:0] v, input int n, output logic [63:0] o);
        o = 64'h0;
        clr_stb();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            o[i] = tdo;
            step(i == n - 1, v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr_stb();
        trst = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        pins_in = 4'h0;
        logic_pins_out = 4'h0;
        user_capture_data = 64'h0;
        @(negedge tck);

        // Reset state
        step(1'b1, 1'b0);
        trst = 1'b1;
        chk("rst_state", tap_state, 4'hF);
        chk("rst_ir", ir_out, 4'h1);
        chk("rst_tdo", tdo, 1'b0);
        chk("rst_tdo_en", tdo_en, 1'b0);
        chk("rst_upd_data", user_update_data, 64'h0);
        chk("rst_strobes", {user_capture_strobe, user_update_strobe}, 4'h0);

        // IDCODE read after reset
        step(1'b0, 1'b0);
        chk("rti_state", tap_state, 4'hC);
        scan_dr(64'h0, 32, rd);
        chk("idcode", rd, 64'h1000_0001);

        // IR capture pattern and BYPASS
        scan_ir(4'hF, ir_rd);
        chk("ir_capture", ir_rd, 4'h1);
        chk("ir_bypass", ir_out, 4'hF);
        scan_dr(64'hD, 4, rd);
        chk("bypass_scan", rd, 64'hA);

        // USER1 write
        scan_ir(4'h9, ir_rd);
        chk("ir_user1", ir_out, 4'h9);
        scan_dr(64'hDEAD_BEEF, 32, rd);
        chk("user1_upd_data", user_update_data, 64'hDEAD_BEEF_0000_0000);
        chk("user1_upd_strobe", upd_or, 2'b10);
        chk("user1_upd_cnt", upd_cnt, 1);
        step(1'b0, 1'b0);
        chk("user1_upd_strobe_low", user_update_strobe, 2'b00);

        // USER1 read
        user_capture_data = 64'h1234_5678_0000_0000;
        scan_dr(64'hDEAD_BEEF, 32, rd);
        chk("user1_read", rd, 64'h1234_5678);
        chk("user1_cap_cnt", cap_cnt, 1);
        chk("user1_cap_strobe", cap_or, 2'b10);

        // Zero-shift scan updates with the captured value
        clr_stb();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("zero_shift_data", user_update_data, 64'h1234_5678_0000_0000);
        chk("zero_shift_strobe", upd_or, 2'b10);

        // SAMPLE/PRELOAD capture and preload of out cells
        pins_in = 4'hA;
        logic_pins_out = 4'h3;
        chk("logic_pins_in", logic_pins_in, 4'hA);
        scan_ir(4'h2, ir_rd);
        scan_dr(64'h05, 8, rd);
        chk("sample_scan", rd, 64'hA3);
        chk("sample_pins_out", pins_out, 4'h3);
        chk("sample_no_user_strobe", cap_cnt + upd_cnt, 0);

        // EXTEST drives the preloaded cells, BYPASS returns to core values
        scan_ir(4'h0, ir_rd);
        chk("extest_pins_out", pins_out, 4'h5);
        logic_pins_out = 4'hC;
        step(1'b0, 1'b0);
        chk("extest_hold", pins_out, 4'h5);
        scan_ir(4'hF, ir_rd);
        chk("bypass_pins_out", pins_out, 4'hC);

        // Unused USER code and illegal code behave as BYPASS
        scan_ir(4'hA, ir_rd);
        scan_dr(64'h3, 2, rd);
        chk("user2_bypass", rd, 64'h2);
        chk("user2_no_strobe", cap_cnt + upd_cnt, 0);
        scan_ir(4'h7, ir_rd);
        chk("ir_illegal", ir_out, 4'h7);
        scan_dr(64'h3, 2, rd);
        chk("illegal_bypass", rd, 64'h2);

        // Five tms=1 from ShDR reaches TLR and restores IDCODE
        clr_stb();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("shdr_tdo_en", tdo_en, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
        end
        chk("tlr_state", tap_state, 4'hF);
        chk("tlr_ir", ir_out, 4'h1);
        chk("tlr_user_data", user_update_data, 64'h1234_5678_0000_0000);
        chk("tlr_no_strobe", upd_cnt, 0);

        // Reset in the middle of a USER0 shift
        step(1'b0, 1'b0);
        scan_ir(4'h8, ir_rd);
        clr_stb();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
        end
        chk("midshift_state", tap_state, 4'h2);
        trst = 1'b0;
        step(1'b0, 1'b1);
        trst = 1'b1;
        chk("midrst_state", tap_state, 4'hF);
        chk("midrst_ir", ir_out, 4'h1);
        chk("midrst_user_data", user_update_data, 64'h0);
        chk("midrst_upd_cnt", upd_cnt, 0);
        chk("midrst_tdo_en", tdo_en, 1'b0);
        chk("midrst_tdo", tdo, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
